// File: rtl/i2s_tx_fifo.sv
// I2S / left-justified stereo transmitter with a frame FIFO and integrated BCK divider.
// All serial state advances only on BCK falling edges generated from the system clock.
module i2s_tx_fifo #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int BCK_DIV     = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int JUSTIFY     = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [2*SAMPLE_BITS-1:0]         i_in_data,
    input  logic                             i_enable,
    output logic                             o_bck,
    output logic                             o_lrck,
    output logic                             o_sout,
    output logic                             o_underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_level
);

    localparam int FW    = 2 * SAMPLE_BITS;
    localparam int BC_W  = $clog2(2 * SLOT_BITS);
    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SLOT_BITS - 1);
    localparam logic [BC_W-1:0]  BC_SLOT  = BC_W'(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Bit of sample s sent at slot position p; I2S delays the MSB by one BCK.
    function automatic logic f_slot_bit(input logic [SAMPLE_BITS-1:0] s, input int p);
        int   idx;
        logic b;
        idx = SAMPLE_BITS - p - JUSTIFY;
        b   = 1'b0;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            b = b | ((i == idx) & s[i]);
        end
        return b;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic             r_bck;
    logic [BC_W-1:0]  r_bc;
    logic             r_lrck;
    logic             r_sout;
    logic             r_underrun;
    logic [FW-1:0]    r_frame;
    logic [FW-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic                   w_fall;
    logic                   w_start;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [BC_W-1:0]        w_bc_next;
    logic [BC_W-1:0]        w_p;
    logic [FW-1:0]          w_frame_next;
    logic [SAMPLE_BITS-1:0] w_sample;
    logic                   w_lrck_next;
    logic                   w_sout_next;

    assign o_in_ready   = (r_level != LVL_FULL);
    assign o_bck        = r_bck;
    assign o_lrck       = r_lrck;
    assign o_sout       = r_sout;
    assign o_underrun   = r_underrun;
    assign o_fifo_level = r_level;

    // Fall-event detection, frame selection and next serial bit.
    always_comb begin
        w_fall    = i_enable && r_bck && (r_div == DIV_LAST);
        w_start   = w_fall && (r_bc == BC_LAST);
        w_empty   = (r_level == {LVL_W{1'b0}});
        w_push    = i_in_valid && o_in_ready;
        w_pop     = w_start && !w_empty;
        w_bc_next = (r_bc == BC_LAST) ? {BC_W{1'b0}} : (r_bc + BC_W'(1));
        if (w_start) begin
            if (w_empty) begin
                w_frame_next = {FW{1'b0}};
            end else begin
                w_frame_next = r_mem[r_rd_ptr];
            end
        end else begin
            w_frame_next = r_frame;
        end
        w_lrck_next = (w_bc_next >= BC_SLOT);
        w_p         = w_lrck_next ? (w_bc_next - BC_SLOT) : w_bc_next;
        w_sample    = w_lrck_next ? w_frame_next[SAMPLE_BITS-1:0] : w_frame_next[FW-1:SAMPLE_BITS];
        w_sout_next = f_slot_bit(w_sample, int'(w_p));
    end

    // BCK divider, bit counter, frame register and serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= {DIV_W{1'b0}};
            r_bck      <= 1'b0;
            r_bc       <= BC_LAST;
            r_lrck     <= 1'b0;
            r_sout     <= 1'b0;
            r_underrun <= 1'b0;
            r_frame    <= {FW{1'b0}};
        end else if (!i_enable) begin
            r_div      <= {DIV_W{1'b0}};
            r_bck      <= 1'b0;
            r_bc       <= BC_LAST;
            r_lrck     <= 1'b0;
            r_sout     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_start && w_empty;
            if (r_div == DIV_LAST) begin
                r_div <= {DIV_W{1'b0}};
                r_bck <= ~r_bck;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_fall) begin
                r_bc    <= w_bc_next;
                r_frame <= w_frame_next;
                r_lrck  <= w_lrck_next;
                r_sout  <= w_sout_next;
            end
        end
    end

    // FIFO storage; stale entries are harmless because pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed bench for i2s_tx_fifo: an I2S and a left-justified instance share stimulus.
module tb_i2s_tx_fifo;

    localparam int SB    = 16;
    localparam int SLOT  = 32;
    localparam int DIV   = 2;
    localparam int DEPTH = 4;
    localparam int FRAME_CLKS = 2 * SLOT * 2 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        enable;
    logic [31:0] in_data;

    logic       ready0, bck0, lrck0, sout0, und0;
    logic [2:0] lvl0;
    logic       ready1, bck1, lrck1, sout1, und1;
    logic [2:0] lvl1;

    i2s_tx_fifo #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .BCK_DIV(DIV), .FIFO_DEPTH(DEPTH), .JUSTIFY(0)) u_i2s (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(ready0), .i_in_data(in_data),
        .i_enable(enable), .o_bck(bck0), .o_lrck(lrck0), .o_sout(sout0), .o_underrun(und0),
        .o_fifo_level(lvl0));

    i2s_tx_fifo #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .BCK_DIV(DIV), .FIFO_DEPTH(DEPTH), .JUSTIFY(1)) u_lj (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(ready1), .i_in_data(in_data),
        .i_enable(enable), .o_bck(bck1), .o_lrck(lrck1), .o_sout(sout1), .o_underrun(und1),
        .o_fifo_level(lvl1));

    always #5 clk = ~clk;

    int          vecs = 0;
    int          fails = 0;
    int          g_cyc = 0;
    int          g_falls = 0;
    int          g_first;
    logic        g_prev_bck = 1'b0;
    int          g_uclk[$];
    logic [63:0] g_so0, g_so1, g_lr;
    int          nu;
    int          base;

    logic [31:0] frames [5] = '{32'h8001_7FFE, 32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_F0F0, 32'hDEAD_BEEF};

    function automatic logic [63:0] exp_i2s(input logic [31:0] f);
        return {1'b0, f[31:16], 15'h0, 1'b0, f[15:0], 15'h0};
    endfunction

    function automatic logic [63:0] exp_lj(input logic [31:0] f);
        return {f[31:16], 16'h0, f[15:0], 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        g_cyc++;
        if (und0) g_uclk.push_back(g_cyc);
        if (g_prev_bck && !bck0) begin
            g_so0 = {g_so0[62:0], sout0};
            g_so1 = {g_so1[62:0], sout1};
            g_lr  = {g_lr[62:0], lrck0};
            g_falls++;
        end
        g_prev_bck = bck0;
    endtask

    task automatic collect(input int n);
        int target;
        int start;
        int k;
        int budget;
        start   = g_falls;
        target  = g_falls + n;
        budget  = (n + 1) * 2 * DIV + 4;
        k       = 0;
        g_first = -1;
        while (g_falls < target && k < budget) begin
            tick();
            k++;
            if (g_first < 0 && g_falls > start) g_first = k;
        end
        if (g_falls < target) chk("collect_timeout", g_falls - start, n);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; enable = 1'b0; in_data = 32'h0;
        repeat (3) tick();
        chk("rst_bck", bck0, 1'b0);
        chk("rst_lrck", lrck0, 1'b0);
        chk("rst_sout", sout0, 1'b0);
        chk("rst_underrun", und0, 1'b0);
        chk("rst_level", lvl0, 3'd0);
        chk("rst_ready", ready0, 1'b1);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("idle_bck", bck0, 1'b0);
        chk("idle_no_underrun", g_uclk.size(), 0);

        // Single I2S / left-justified frame
        in_data = 32'hA5F0_0F3C; in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("b_level", lvl0, 3'd1);
        nu = g_uclk.size();
        enable = 1'b1;
        collect(64);
        chk("b_first_fall", g_first, 2 * DIV);
        chk("b_i2s", g_so0, 64'h52F8_0000_079E_0000);
        chk("b_lj", g_so1, 64'hA5F0_0000_0F3C_0000);
        chk("b_lrck", g_lr, 64'h0000_0000_FFFF_FFFF);
        chk("b_level_after", lvl0, 3'd0);
        chk("b_underruns", g_uclk.size() - nu, 0);
        enable = 1'b0;
        tick();
        chk("dis_lrck", lrck0, 1'b0);
        chk("dis_bck", bck0, 1'b0);
        chk("dis_sout", sout0, 1'b0);

        // FIFO full while disabled, then drain in order
        for (int i = 0; i < 5; i++) begin
            in_data = frames[i]; in_valid = 1'b1;
            chk($sformatf("full_ready%0d", i), ready0, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_level", lvl0, 3'd4);
        chk("full_ready", ready0, 1'b0);
        nu = g_uclk.size();
        enable = 1'b1;
        collect(1);
        chk("c_first_fall", g_first, 2 * DIV);
        chk("c_level3", lvl0, 3'd3);
        chk("c_ready", ready0, 1'b1);
        collect(63);
        chk("c_i2s0", g_so0, exp_i2s(frames[0]));
        chk("c_lj0", g_so1, exp_lj(frames[0]));
        for (int i = 1; i < 4; i++) begin
            collect(64);
            chk($sformatf("c_i2s%0d", i), g_so0, exp_i2s(frames[i]));
            chk($sformatf("c_lj%0d", i), g_so1, exp_lj(frames[i]));
        end
        chk("c_underruns", g_uclk.size() - nu, 0);
        chk("c_level0", lvl0, 3'd0);

        // Underrun frames; a push during the third one is sent in the fourth
        nu = g_uclk.size();
        collect(64);
        chk("d_u1_sout", g_so0 | g_so1, 64'h0);
        collect(64);
        chk("d_u2_sout", g_so0 | g_so1, 64'h0);
        base = g_falls;
        collect(10);
        in_data = 32'h8001_4002; in_valid = 1'b1; tick(); in_valid = 1'b0;
        collect(base + 64 - g_falls);
        chk("d_u3_sout", g_so0 | g_so1, 64'h0);
        chk("d_underruns", g_uclk.size() - nu, 3);
        if (g_uclk.size() - nu >= 3) begin
            chk("d_gap12", g_uclk[nu + 1] - g_uclk[nu], FRAME_CLKS);
            chk("d_gap23", g_uclk[nu + 2] - g_uclk[nu + 1], FRAME_CLKS);
        end
        collect(64);
        chk("d_push_i2s", g_so0, exp_i2s(32'h8001_4002));
        chk("d_push_lj", g_so1, exp_lj(32'h8001_4002));
        chk("d_no_underrun", g_uclk.size() - nu, 3);

        // Enable dropped mid right slot, queued frame retained
        in_data = 32'h1357_9BDF; in_valid = 1'b1; tick();
        in_data = 32'h2468_ACE0; tick(); in_valid = 1'b0;
        collect(1);
        chk("e_level", lvl0, 3'd1);
        collect(40);
        chk("e_lrck_before", lrck0, 1'b1);
        enable = 1'b0;
        tick();
        chk("e_dis_lrck", lrck0, 1'b0);
        chk("e_dis_bck", bck0, 1'b0);
        chk("e_dis_sout", sout0, 1'b0);
        repeat (5) tick();
        chk("e_level_kept", lvl0, 3'd1);
        nu = g_uclk.size();
        enable = 1'b1;
        collect(64);
        chk("e_first_fall", g_first, 2 * DIV);
        chk("e_i2s", g_so0, exp_i2s(32'h2468_ACE0));
        chk("e_lj", g_so1, exp_lj(32'h2468_ACE0));
        chk("e_level0", lvl0, 3'd0);
        chk("e_underruns", g_uclk.size() - nu, 0);

        // Reset mid-frame with three frames queued
        for (int i = 0; i < 4; i++) begin
            in_data = frames[i]; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        collect(40);
        chk("f_level3", lvl0, 3'd3);
        rst_n = 1'b0;
        #1;
        chk("f_rst_bck", bck0, 1'b0);
        chk("f_rst_lrck", lrck0, 1'b0);
        chk("f_rst_sout", sout0, 1'b0);
        chk("f_rst_level", lvl0, 3'd0);
        chk("f_rst_ready", ready0, 1'b1);
        g_prev_bck = 1'b0;
        repeat (2) tick();
        chk("f_hold_bck", bck0, 1'b0);
        rst_n = 1'b1;
        nu = g_uclk.size();
        collect(1);
        chk("f_first_fall", g_first, 2 * DIV);
        chk("f_underrun", g_uclk.size() - nu, 1);
        if (g_uclk.size() > nu) chk("f_underrun_clk", g_uclk[nu], g_cyc);
        chk("f_level", lvl0, 3'd0);
        tick();
        chk("f_underrun_pulse", und0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Parametrised I2S/left-justified stereo transmitter with an internal sample FIFO and an integrated BCK divider. Everything runs in one system clock domain, so the sender needs no cross-domain handshake. Sample width, slot width, bit-clock rate, FIFO depth and justification mode are all configurable. It sits between the NeXT sound-out sample path and the external DAC and reports underruns.

Parameters:
SAMPLE_BITS, 16, bits per channel sample; 1..SLOT_BITS-1 when JUSTIFY=0, 1..SLOT_BITS when JUSTIFY=1
SLOT_BITS, 32, BCK periods per channel slot; one frame is 2*SLOT_BITS BCK periods
BCK_DIV, 4, clk cycles per BCK half-period; must be >=1
FIFO_DEPTH, 4, stereo frames buffered; power of 2, >=2
JUSTIFY, 0, 0 = I2S (MSB one BCK after LRCK edge), 1 = left-justified (MSB coincident with LRCK edge)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data holds a frame
in_ready  out  1  FIFO not full
in_data  in  2*SAMPLE_BITS  {left[MSBs], right[LSBs]}
enable  in  1  1 = run serial interface
bck  out  1  bit clock, clk/(2*BCK_DIV)
lrck  out  1  0 = left slot, 1 = right slot
sout  out  1  serial data, changes only with bck falling
underrun  out  1  one-clk pulse when a frame starts with the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  frames currently stored

Behaviour:
- Reset (async, rst_n=0):
  - bck=0, lrck=0, sout=0, underrun=0, fifo_level=0, in_ready=1.
  - FIFO pointers cleared; divider counter 0; bit counter = 2*SLOT_BITS-1; frame register 0.
  - Asserting reset mid-frame discards FIFO contents and the frame in progress.
- Push: accepted on a clk edge when in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH), combinational from level. No push when full.
- Divider (enable=1):
  - div counter counts 0..BCK_DIV-1; at BCK_DIV-1 it wraps and bck toggles.
  - A "fall event" is the clk cycle where bck toggles 1->0; all serial state updates on fall events only.
- Bit counter bc (0..2*SLOT_BITS-1): increments on every fall event; wraps from 2*SLOT_BITS-1 to 0.
- Frame start (fall event where bc wraps to 0):
  - FIFO non-empty: pop the head into the frame register; fifo_level decrements.
  - FIFO empty: frame register = 0; underrun=1 for that single clk.
- Outputs, registered on the fall event using the new bc. Let p = bc mod SLOT_BITS and S = left sample when bc<SLOT_BITS, else right sample.
  - lrck = (bc >= SLOT_BITS).
  - JUSTIFY=1: sout = S[SAMPLE_BITS-1-p] for p<SAMPLE_BITS, else 0.
  - JUSTIFY=0: sout = S[SAMPLE_BITS-p] for 1<=p<=SAMPLE_BITS, else 0 (p=0 gives 0).
- Simultaneous push and pop in one clk: fifo_level unchanged. Push into an empty FIFO in the same clk as a frame start: no bypass; underrun fires and the pushed frame waits for the next frame start.
- enable=0:
  - bck, lrck, sout forced 0 from the next clk; divider cleared; bc set to 2*SLOT_BITS-1; no pops, no underrun.
  - Pushes still accepted.
  - When enable returns to 1, the first fall event occurs 2*BCK_DIV clks later and starts a new frame.
- fifo_level saturates at neither end; pointer wrap is modulo FIFO_DEPTH.
- Bits of in_data beyond SAMPLE_BITS do not exist; no padding/sign handling, zeros fill unused slot bits.

Test Plan:
- Reset: assert rst_n=0 mid-frame with 3 frames queued -> bck=lrck=sout=0, fifo_level=0, in_ready=1 immediately; after release, first fall event at clk 2*BCK_DIV with underrun pulse.
- I2S frame (SAMPLE_BITS=16, SLOT_BITS=32, BCK_DIV=2, JUSTIFY=0): push {16'hA5F0,16'h0F3C} then enable -> lrck 0 for 32 BCKs then 1 for 32. sout is 0, then 1010010111110000, then 15 zeros in the left slot; 0, then 0000111100111100, then 15 zeros in the right slot.
- Left-justified (JUSTIFY=1), same data -> the MSB 1 appears on the same fall event as lrck goes 0; bit 16 of each slot onward is 0.
- FIFO full: enable=0, push 5 frames back-to-back -> first 4 accepted, fifo_level=4, in_ready=0 on 5th. Enable -> level 3 after first frame start, in_ready=1; frames emitted in push order.
- Underrun: enable with empty FIFO for 3 frames -> sout constant 0, exactly 3 one-clk underrun pulses, 2*SLOT_BITS*2*BCK_DIV clks apart. Push during frame 2 -> emitted in frame 3 with no underrun that frame.
- Enable toggle: deassert enable mid-right-slot -> outputs 0 next clk, queued frames retained. Re-enable -> next frame starts with left slot from the FIFO head.
